asg_seq_ctrl: RTL and testbench

Segment sequencer that drives one arbitrary-signal-generator channel through a programmed list of waveform segments. Each segment is a buffer offset, size, cycle count and post-segment gap. The block sits beside the ASG channel in the DAC clock domain. It drives the channel's offset/size/cycle-count configuration, reset and software trigger, and counts the channel's completion pulses to advance.

---
 rtl/asg_seq_pkg.sv | 26 ++
 rtl/asg_seq_if.sv | 48 ++++
 rtl/asg_seq_table.sv | 82 ++++++++
 rtl/asg_seq_ctrl.sv | 159 +++++++++++++++
 tb/tb_asg_seq_ctrl.sv | 416 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/asg_seq_pkg.sv
// asg_seq_ctrl shared types: FSM encoding, table field selects, blanking length.
// Optional build macro: ASG_SEQ_READBACK_EN (table readback port).
package asg_seq_pkg;

  localparam int BLANK_LEN = 2;

  localparam logic [1:0] FLD_OFS  = 2'd0;
  localparam logic [1:0] FLD_SIZE = 2'd1;
  localparam logic [1:0] FLD_NCYC = 2'd2;
  localparam logic [1:0] FLD_GAP  = 2'd3;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_LOAD = 3'd1,
    S_TRIG = 3'd2,
    S_RUN  = 3'd3,
    S_GAP  = 3'd4
  } state_t;

  function automatic logic [31:0] sat_inc(
    input logic [31:0] v
  );
    return (&v) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/asg_seq_if.sv
// asg_seq_ctrl bus: config table port, sequence control and channel drive.
// slave = sequencer side, master = host/channel side.
interface asg_seq_if #(
  parameter int RSZ        = 14,
  parameter int NSEG       = 8,
  parameter int CYCLE_BITS = 32,
  parameter int SW         = $clog2(NSEG)
) ();

  logic                  cfg_we_i;
  logic [SW+1:0]         cfg_addr_i;
  logic [31:0]           cfg_wdata_i;
  logic [31:0]           cfg_rdata_o;
  logic [SW-1:0]         seq_last_i;
  logic                  seq_loop_i;
  logic                  start_i;
  logic                  stop_i;
  logic                  trig_done_i;
  logic [RSZ+15:0]       ch_ofs_o;
  logic [RSZ+15:0]       ch_size_o;
  logic [CYCLE_BITS-1:0] ch_ncyc_o;
  logic                  ch_rst_o;
  logic                  ch_trig_o;
  logic                  busy_o;
  logic [SW-1:0]         seg_o;
  logic                  done_o;

  modport slave (
    input  cfg_we_i, cfg_addr_i, cfg_wdata_i,
    input  seq_last_i, seq_loop_i,
    input  start_i, stop_i, trig_done_i,
    output cfg_rdata_o,
    output ch_ofs_o, ch_size_o, ch_ncyc_o,
    output ch_rst_o, ch_trig_o,
    output busy_o, seg_o, done_o
  );

  modport master (
    output cfg_we_i, cfg_addr_i, cfg_wdata_i,
    output seq_last_i, seq_loop_i,
    output start_i, stop_i, trig_done_i,
    input  cfg_rdata_o,
    input  ch_ofs_o, ch_size_o, ch_ncyc_o,
    input  ch_rst_o, ch_trig_o,
    input  busy_o, seg_o, done_o
  );

endinterface

// File: rtl/asg_seq_table.sv
// Segment table: write port, async read for LOAD, optional registered readback.
// Readback present only with ASG_SEQ_READBACK_EN defined.
module asg_seq_table
  import asg_seq_pkg::*;
#(
  parameter int RSZ        = 14,
  parameter int NSEG       = 8,
  parameter int CYCLE_BITS = 32,
  parameter int SW         = $clog2(NSEG)
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_we,
  input  logic [SW+1:0]         i_addr,
  input  logic [31:0]           i_wdata,
  input  logic [SW-1:0]         i_rd_idx,
  output logic [RSZ+15:0]       o_ofs,
  output logic [RSZ+15:0]       o_size,
  output logic [CYCLE_BITS-1:0] o_ncyc,
  output logic [31:0]           o_gap,
  output logic [31:0]           o_rdata
);

  logic [RSZ+15:0]       r_ofs  [NSEG];
  logic [RSZ+15:0]       r_size [NSEG];
  logic [CYCLE_BITS-1:0] r_ncyc [NSEG];
  logic [31:0]           r_gap  [NSEG];

  logic [SW-1:0] w_seg;
  logic [1:0]    w_fld;

  assign w_seg = i_addr[SW+1:2];
  assign w_fld = i_addr[1:0];

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < NSEG; i++) begin
        r_ofs[i]  <= '0;
        r_size[i] <= '0;
        r_ncyc[i] <= '0;
        r_gap[i]  <= '0;
      end
    end else if (i_we) begin
      unique case (w_fld)
        FLD_OFS:  r_ofs[w_seg]  <= (RSZ+16)'(i_wdata);
        FLD_SIZE: r_size[w_seg] <= (RSZ+16)'(i_wdata);
        FLD_NCYC: r_ncyc[w_seg] <= CYCLE_BITS'(i_wdata);
        FLD_GAP:  r_gap[w_seg]  <= i_wdata;
      endcase
    end
  end

  assign o_ofs  = r_ofs[i_rd_idx];
  assign o_size = r_size[i_rd_idx];
  assign o_ncyc = r_ncyc[i_rd_idx];
  assign o_gap  = r_gap[i_rd_idx];

`ifdef ASG_SEQ_READBACK_EN
  logic [31:0] r_rdata;
  logic [31:0] w_rb;

  always_comb begin
    w_rb = '0;
    unique case (w_fld)
      FLD_OFS:  w_rb = 32'(r_ofs[w_seg]);
      FLD_SIZE: w_rb = 32'(r_size[w_seg]);
      FLD_NCYC: w_rb = 32'(r_ncyc[w_seg]);
      FLD_GAP:  w_rb = r_gap[w_seg];
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_rdata <= '0;
    else          r_rdata <= w_rb;
  end

  assign o_rdata = r_rdata;
`else
  assign o_rdata = '0;
`endif

endmodule

// File: rtl/asg_seq_ctrl.sv
// ASG segment sequencer: FSM, wrap/gap counters, channel output registers.
// Build option ASG_SEQ_READBACK_EN enables table readback on cfg_rdata_o.
module asg_seq_ctrl
  import asg_seq_pkg::*;
#(
  parameter int RSZ        = 14,
  parameter int NSEG       = 8,
  parameter int CYCLE_BITS = 32,
  parameter int SW         = $clog2(NSEG)
) (
  input  logic      dac_clk_i,
  input  logic      dac_rstn_i,
  asg_seq_if.slave  bus
);

  localparam logic [SW-1:0] LAST_MAX = SW'(NSEG - 1);

  state_t r_state, w_state_nxt, w_adv_tgt;

  logic [SW-1:0]         r_seg, w_seg_nxt, w_last;
  logic [31:0]           r_wrap, w_wrap_nxt;
  logic [31:0]           r_gcnt, r_gap;
  logic [1:0]            r_blank;
  logic [RSZ+15:0]       r_ch_ofs, r_ch_size;
  logic [CYCLE_BITS-1:0] r_ch_ncyc;
  logic                  r_rst, r_trig, r_busy, r_done;

  logic                  w_stop, w_count, w_hit;
  logic                  w_gap_end, w_adv, w_more;
  logic                  w_load, w_rst_nxt, w_trig_nxt, w_done_nxt;
  logic [RSZ+15:0]       w_t_ofs, w_t_size;
  logic [CYCLE_BITS-1:0] w_t_ncyc;
  logic [31:0]           w_t_gap;

  asg_seq_table #(
    .RSZ        (RSZ),
    .NSEG       (NSEG),
    .CYCLE_BITS (CYCLE_BITS),
    .SW         (SW)
  ) u_table (
    .i_clk    (dac_clk_i),
    .i_rst_n  (dac_rstn_i),
    .i_we     (bus.cfg_we_i),
    .i_addr   (bus.cfg_addr_i),
    .i_wdata  (bus.cfg_wdata_i),
    .i_rd_idx (w_seg_nxt),
    .o_ofs    (w_t_ofs),
    .o_size   (w_t_size),
    .o_ncyc   (w_t_ncyc),
    .o_gap    (w_t_gap),
    .o_rdata  (bus.cfg_rdata_o)
  );

  always_ff @(posedge dac_clk_i or negedge dac_rstn_i) begin
    if (!dac_rstn_i) r_state <= S_IDLE;
    else             r_state <= w_state_nxt;
  end

  always_comb begin
    w_last = (bus.seq_last_i < LAST_MAX) ?
             bus.seq_last_i : LAST_MAX;
    w_more = r_seg < w_last;
    w_stop = bus.stop_i && (r_state != S_IDLE);
    // trig_done is ignored while the trigger echo is blanked
    w_count = (r_state == S_RUN) &&
              (r_blank == 2'd0) && bus.trig_done_i;
    w_wrap_nxt = w_count ? sat_inc(r_wrap) : r_wrap;
    w_hit = w_count && (r_ch_ncyc != '0) &&
            (w_wrap_nxt == 32'(r_ch_ncyc));
    w_gap_end = (r_state == S_GAP) &&
                (sat_inc(r_gcnt) >= r_gap);
    w_adv = (w_hit && (r_gap == 32'd0)) || w_gap_end;
    w_adv_tgt = (w_more || bus.seq_loop_i) ?
                S_LOAD : S_IDLE;
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE: begin
        if (bus.start_i && !bus.stop_i)
          w_state_nxt = S_LOAD;
      end
      S_LOAD: w_state_nxt = S_TRIG;
      S_TRIG: w_state_nxt = S_RUN;
      S_RUN: begin
        if (w_hit)
          w_state_nxt = (r_gap != 32'd0) ?
                        S_GAP : w_adv_tgt;
      end
      S_GAP: begin
        if (w_gap_end) w_state_nxt = w_adv_tgt;
      end
      default: w_state_nxt = S_IDLE;
    endcase
    if (w_stop) w_state_nxt = S_IDLE;
  end

  always_comb begin
    w_load = (w_state_nxt == S_LOAD);
    w_seg_nxt = r_seg;
    unique case (1'b1)
      (r_state == S_IDLE) && w_load:
        w_seg_nxt = '0;
      w_adv && w_load:
        w_seg_nxt = w_more ? r_seg + 1'b1 : '0;
      default: w_seg_nxt = r_seg;
    endcase
    w_done_nxt = w_adv && !w_stop &&
                 (w_state_nxt == S_IDLE);
    w_rst_nxt  = w_load || w_stop || w_done_nxt;
    w_trig_nxt = (w_state_nxt == S_TRIG);
  end

  always_ff @(posedge dac_clk_i or negedge dac_rstn_i) begin
    if (!dac_rstn_i) begin
      r_seg     <= '0;
      r_rst     <= 1'b0;
      r_trig    <= 1'b0;
      r_done    <= 1'b0;
      r_busy    <= 1'b0;
      r_ch_ofs  <= '0;
      r_ch_size <= '0;
      r_ch_ncyc <= '0;
      r_gap     <= '0;
      r_wrap    <= '0;
      r_blank   <= '0;
      r_gcnt    <= '0;
    end else begin
      r_seg  <= w_seg_nxt;
      r_rst  <= w_rst_nxt;
      r_trig <= w_trig_nxt;
      r_done <= w_done_nxt;
      r_busy <= (w_state_nxt != S_IDLE);
      if (w_load) begin
        r_ch_ofs  <= w_t_ofs;
        r_ch_size <= w_t_size;
        r_ch_ncyc <= w_t_ncyc;
        r_gap     <= w_t_gap;
      end
      if (r_state == S_TRIG) begin
        r_wrap  <= '0;
        r_blank <= 2'(BLANK_LEN);
      end else if (r_state == S_RUN) begin
        r_wrap <= w_wrap_nxt;
        if (r_blank != 2'd0) r_blank <= r_blank - 2'd1;
      end
      if (r_state == S_GAP) r_gcnt <= sat_inc(r_gcnt);
      else                  r_gcnt <= '0;
    end
  end

  assign bus.ch_ofs_o  = r_ch_ofs;
  assign bus.ch_size_o = r_ch_size;
  assign bus.ch_ncyc_o = r_ch_ncyc;
  assign bus.ch_rst_o  = r_rst;
  assign bus.ch_trig_o = r_trig;
  assign bus.busy_o    = r_busy;
  assign bus.seg_o     = r_seg;
  assign bus.done_o    = r_done;

endmodule

// File: tb/tb_asg_seq_ctrl.sv
// Self-checking bench for asg_seq_ctrl: scenario tasks plus a
// scoreboard of expected segment loads and done pulses.
module tb_asg_seq_ctrl;
  import asg_seq_pkg::*;

  localparam int RSZ  = 14;
  localparam int NSEG = 8;
  localparam int CB   = 32;
  localparam int SW   = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  asg_seq_if #(
    .RSZ(RSZ), .NSEG(NSEG), .CYCLE_BITS(CB), .SW(SW)
  ) bus ();

  asg_seq_ctrl #(
    .RSZ(RSZ), .NSEG(NSEG), .CYCLE_BITS(CB), .SW(SW)
  ) dut (
    .dac_clk_i  (clk),
    .dac_rstn_i (rst_n),
    .bus        (bus)
  );

  typedef struct {
    logic [SW-1:0]    seg;
    logic [RSZ+15:0]  ofs;
  } ld_t;

  ld_t exp_ld[$];
  bit  exp_done[$];
  int  nchk = 0;
  int  nerr = 0;
  bit  mon_en = 1'b0;

  always @(negedge clk) begin
    ld_t e;
    if (mon_en && rst_n) begin
      if (bus.ch_rst_o && bus.busy_o) begin
        nchk++;
        if (exp_ld.size() == 0) begin
          nerr++;
          $display("FAIL load_unexpected seg=%0d ofs=%h",
                   bus.seg_o, bus.ch_ofs_o);
        end else begin
          e = exp_ld.pop_front();
          if (bus.seg_o !== e.seg || bus.ch_ofs_o !== e.ofs) begin
            nerr++;
            $display("FAIL load_seq got seg=%0d ofs=%h exp seg=%0d ofs=%h",
                     bus.seg_o, bus.ch_ofs_o, e.seg, e.ofs);
          end
        end
      end
      if (bus.done_o) begin
        nchk++;
        if (exp_done.size() == 0) begin
          nerr++;
          $display("FAIL done_unexpected t=%0t", $time);
        end else begin
          void'(exp_done.pop_front());
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wr(input int seg, input int fld,
                    input logic [31:0] d);
    bus.cfg_we_i    = 1'b1;
    bus.cfg_addr_i  = (SW+2)'(seg * 4 + fld);
    bus.cfg_wdata_i = d;
    cyc(1);
    bus.cfg_we_i    = 1'b0;
  endtask

  task automatic set_seg(input int seg, input logic [31:0] ofs,
                         input logic [31:0] size,
                         input logic [31:0] ncyc,
                         input logic [31:0] gap);
    wr(seg, 0, ofs);
    wr(seg, 1, size);
    wr(seg, 2, ncyc);
    wr(seg, 3, gap);
  endtask

  task automatic push_ld(input int s, input logic [31:0] o);
    ld_t e;
    e.seg = SW'(s);
    e.ofs = (RSZ+16)'(o);
    exp_ld.push_back(e);
  endtask

  task automatic pulse_start;
    bus.start_i = 1'b1;
    cyc(1);
    bus.start_i = 1'b0;
  endtask

  task automatic pulse_stop;
    bus.stop_i = 1'b1;
    cyc(1);
    bus.stop_i = 1'b0;
  endtask

  task automatic wrap;
    bus.trig_done_i = 1'b1;
    cyc(1);
    bus.trig_done_i = 1'b0;
  endtask

  task automatic test_reset;
    bus.cfg_we_i = 0; bus.cfg_addr_i = '0; bus.cfg_wdata_i = '0;
    bus.seq_last_i = '0; bus.seq_loop_i = 0;
    bus.start_i = 0; bus.stop_i = 0; bus.trig_done_i = 0;
    rst_n = 1'b0;
    cyc(2);
    nchk++;
    if ({bus.busy_o, bus.seg_o, bus.done_o,
         bus.ch_rst_o, bus.ch_trig_o} !== '0) begin
      nerr++;
      $display("FAIL reset_ctrl busy=%b seg=%0d done=%b rst=%b trig=%b exp all 0",
               bus.busy_o, bus.seg_o, bus.done_o,
               bus.ch_rst_o, bus.ch_trig_o);
    end
    nchk++;
    if ({bus.ch_ofs_o, bus.ch_size_o, bus.ch_ncyc_o,
         bus.cfg_rdata_o} !== '0) begin
      nerr++;
      $display("FAIL reset_data ofs=%h size=%h ncyc=%h rdata=%h exp 0",
               bus.ch_ofs_o, bus.ch_size_o, bus.ch_ncyc_o,
               bus.cfg_rdata_o);
    end
    rst_n = 1'b1;
    cyc(1);
  endtask

  task automatic test_three_seg;
    int n;
    set_seg(0, 32'h0, 32'h3FFF_FFFF, 2, 0);
    set_seg(1, 32'h40, 32'h20, 1, 10);
    set_seg(2, 32'h80, 32'h10, 3, 0);
    bus.seq_last_i = 3'd2;
    bus.seq_loop_i = 1'b0;
    push_ld(0, 32'h0);
    push_ld(1, 32'h40);
    push_ld(2, 32'h80);
    exp_done.push_back(1'b1);
    pulse_start;
    nchk++;
    if ({bus.busy_o, bus.ch_rst_o, bus.ch_trig_o,
         bus.ch_size_o, bus.ch_ncyc_o} !==
        {3'b110, 30'h3FFF_FFFF, 32'd2}) begin
      nerr++;
      $display("FAIL seq_load busy=%b rst=%b trig=%b size=%h ncyc=%0d exp 1 1 0 3fffffff 2",
               bus.busy_o, bus.ch_rst_o, bus.ch_trig_o,
               bus.ch_size_o, bus.ch_ncyc_o);
    end
    cyc(1);
    nchk++;
    if ({bus.ch_trig_o, bus.ch_rst_o} !== 2'b10) begin
      nerr++;
      $display("FAIL seq_trig trig=%b rst=%b exp trig=1 rst=0",
               bus.ch_trig_o, bus.ch_rst_o);
    end
    cyc(3);
    wrap;
    cyc(2);
    wrap;
    nchk++;
    if ({bus.seg_o, bus.ch_rst_o} !== {3'd1, 1'b1}) begin
      nerr++;
      $display("FAIL seg1_load seg=%0d rst=%b exp seg=1 rst=1",
               bus.seg_o, bus.ch_rst_o);
    end
    cyc(4);
    wrap;
    nchk++;
    if ({bus.busy_o, bus.ch_rst_o, bus.seg_o} !==
        {2'b10, 3'd1}) begin
      nerr++;
      $display("FAIL gap_enter busy=%b rst=%b seg=%0d exp 1 0 1",
               bus.busy_o, bus.ch_rst_o, bus.seg_o);
    end
    n = 0;
    while (!bus.ch_rst_o && n < 40) begin
      cyc(1);
      n++;
    end
    nchk++;
    if (n !== 10) begin
      nerr++;
      $display("FAIL gap_len got %0d cycles exp 10", n);
    end
    cyc(4);
    wrap;
    cyc(1);
    wrap;
    cyc(1);
    wrap;
    nchk++;
    if ({bus.done_o, bus.busy_o, bus.ch_rst_o} !== 3'b101) begin
      nerr++;
      $display("FAIL seq_done done=%b busy=%b rst=%b exp 1 0 1",
               bus.done_o, bus.busy_o, bus.ch_rst_o);
    end
    cyc(1);
    nchk++;
    if ({bus.done_o, bus.ch_rst_o} !== 2'b00) begin
      nerr++;
      $display("FAIL done_width done=%b rst=%b exp 0 0",
               bus.done_o, bus.ch_rst_o);
    end
  endtask

  task automatic test_blanking;
    set_seg(0, 32'h11, 32'h22, 1, 0);
    bus.seq_last_i = 3'd0;
    bus.seq_loop_i = 1'b0;
    push_ld(0, 32'h11);
    exp_done.push_back(1'b1);
    pulse_start;
    bus.trig_done_i = 1'b1;
    cyc(4);
    bus.trig_done_i = 1'b0;
    cyc(3);
    nchk++;
    if ({bus.busy_o, bus.done_o, bus.seg_o} !==
        {2'b10, 3'd0}) begin
      nerr++;
      $display("FAIL blank_hold busy=%b done=%b seg=%0d exp 1 0 0",
               bus.busy_o, bus.done_o, bus.seg_o);
    end
    wrap;
    nchk++;
    if ({bus.done_o, bus.busy_o} !== 2'b10) begin
      nerr++;
      $display("FAIL blank_adv done=%b busy=%b exp 1 0",
               bus.done_o, bus.busy_o);
    end
    cyc(1);
  endtask

  task automatic test_loop_live;
    logic [SW-1:0] es;
    set_seg(0, 32'h10, 32'h8, 1, 0);
    set_seg(1, 32'h40, 32'h8, 1, 0);
    bus.seq_last_i = 3'd1;
    bus.seq_loop_i = 1'b1;
    push_ld(0, 32'h10);
    push_ld(1, 32'h40);
    push_ld(0, 32'h100);
    push_ld(1, 32'h40);
    push_ld(0, 32'h100);
    pulse_start;
    cyc(4);
    wr(0, FLD_OFS, 32'h100);
    nchk++;
    if (bus.ch_ofs_o !== 30'h10) begin
      nerr++;
      $display("FAIL live_write_hold ofs=%h exp 10", bus.ch_ofs_o);
    end
    wrap;
    for (int i = 0; i < 3; i++) begin
      cyc(4);
      wrap;
      es = (i % 2 == 0) ? 3'd0 : 3'd1;
      nchk++;
      if ({bus.seg_o, bus.ch_rst_o, bus.done_o} !==
          {es, 2'b10}) begin
        nerr++;
        $display("FAIL loop_seg i=%0d seg=%0d rst=%b done=%b exp seg=%0d 1 0",
                 i, bus.seg_o, bus.ch_rst_o, bus.done_o, es);
      end
    end
    cyc(4);
    pulse_stop;
    nchk++;
    if ({bus.ch_rst_o, bus.busy_o, bus.done_o} !== 3'b100) begin
      nerr++;
      $display("FAIL loop_stop rst=%b busy=%b done=%b exp 1 0 0",
               bus.ch_rst_o, bus.busy_o, bus.done_o);
    end
    cyc(1);
    nchk++;
    if ({bus.ch_rst_o, bus.busy_o} !== 2'b00) begin
      nerr++;
      $display("FAIL stop_idle rst=%b busy=%b exp 0 0",
               bus.ch_rst_o, bus.busy_o);
    end
  endtask

  task automatic test_edges;
    bus.start_i = 1'b1;
    bus.stop_i  = 1'b1;
    cyc(1);
    bus.start_i = 1'b0;
    bus.stop_i  = 1'b0;
    nchk++;
    if ({bus.busy_o, bus.ch_rst_o} !== 2'b00) begin
      nerr++;
      $display("FAIL start_stop busy=%b rst=%b exp 0 0",
               bus.busy_o, bus.ch_rst_o);
    end
    set_seg(0, 32'h20, 32'h8, 0, 0);
    bus.seq_last_i = 3'd0;
    bus.seq_loop_i = 1'b0;
    push_ld(0, 32'h20);
    pulse_start;
    cyc(4);
    pulse_start;
    nchk++;
    if ({bus.seg_o, bus.ch_rst_o, bus.ch_trig_o, bus.busy_o} !==
        {3'd0, 3'b001}) begin
      nerr++;
      $display("FAIL start_busy seg=%0d rst=%b trig=%b busy=%b exp 0 0 0 1",
               bus.seg_o, bus.ch_rst_o, bus.ch_trig_o, bus.busy_o);
    end
    bus.trig_done_i = 1'b1;
    cyc(1000);
    bus.trig_done_i = 1'b0;
    cyc(1);
    nchk++;
    if ({bus.busy_o, bus.done_o, bus.seg_o} !==
        {2'b10, 3'd0}) begin
      nerr++;
      $display("FAIL ncyc0_run busy=%b done=%b seg=%0d exp 1 0 0",
               bus.busy_o, bus.done_o, bus.seg_o);
    end
    pulse_stop;
    nchk++;
    if ({bus.busy_o, bus.ch_rst_o, bus.done_o} !== 3'b010) begin
      nerr++;
      $display("FAIL ncyc0_stop busy=%b rst=%b done=%b exp 0 1 0",
               bus.busy_o, bus.ch_rst_o, bus.done_o);
    end
    cyc(1);
  endtask

  task automatic test_reset_mid;
    set_seg(0, 32'h100, 32'h8, 1, 0);
    set_seg(1, 32'h40, 32'h8, 1, 0);
    bus.seq_last_i = 3'd1;
    bus.seq_loop_i = 1'b1;
    push_ld(0, 32'h100);
    push_ld(1, 32'h40);
    pulse_start;
    cyc(4);
    wrap;
    cyc(4);
    #2 rst_n = 1'b0;
    #1;
    nchk++;
    if ({bus.busy_o, bus.seg_o, bus.done_o,
         bus.ch_rst_o, bus.ch_trig_o} !== '0) begin
      nerr++;
      $display("FAIL async_rst_ctrl busy=%b seg=%0d done=%b rst=%b exp 0",
               bus.busy_o, bus.seg_o, bus.done_o, bus.ch_rst_o);
    end
    nchk++;
    if ({bus.ch_ofs_o, bus.ch_size_o, bus.ch_ncyc_o} !== '0) begin
      nerr++;
      $display("FAIL async_rst_data ofs=%h size=%h ncyc=%h exp 0",
               bus.ch_ofs_o, bus.ch_size_o, bus.ch_ncyc_o);
    end
    cyc(1);
    rst_n = 1'b1;
    bus.cfg_addr_i = {3'd1, FLD_OFS};
    cyc(1);
    nchk++;
    if (bus.cfg_rdata_o !== 32'd0) begin
      nerr++;
      $display("FAIL table_clear rdata=%h exp 0", bus.cfg_rdata_o);
    end
`ifdef ASG_SEQ_READBACK_EN
    wr(1, FLD_SIZE, 32'hFFFF_1234);
    cyc(1);
    nchk++;
    if (bus.cfg_rdata_o !== 32'h3FFF_1234) begin
      nerr++;
      $display("FAIL readback rdata=%h exp 3fff1234",
               bus.cfg_rdata_o);
    end
`endif
  endtask

  initial begin
    test_reset;
    mon_en = 1'b1;
    test_three_seg;
    test_blanking;
    test_loop_live;
    test_edges;
    test_reset_mid;
    mon_en = 1'b0;
    nchk++;
    if (exp_ld.size() != 0 || exp_done.size() != 0) begin
      nerr++;
      $display("FAIL scoreboard_left loads=%0d dones=%0d exp 0 0",
               exp_ld.size(), exp_done.size());
    end
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
